// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 8-bit bus CPU: walks fetch/execute T-states and decodes bus strobes.
// Strobes are combinational from the registered state plus opcode/flags; the state advances one step per enabled clock.
// run_en=0 freezes the state and forces every strobe low. Optional macro: CTRL_EARLY_END_EN (end each instruction after its last strobe step).
module cpu_ctrl_seq #(
  parameter int OP_W    = 4,
  parameter int T_STEPS = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_in,
  output logic            ram_in,
  output logic            ram_out,
  output logic            ir_in,
  output logic            ir_out,
  output logic            a_in,
  output logic            a_out,
  output logic            b_in,
  output logic            alu_out,
  output logic            alu_sub,
  output logic            flags_in,
  output logic            out_in,
  output logic            halt,
  output logic [2:0]      t_state
);

  // T-states occupy codes 0..7 so the step index is just the low three bits.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RST = 4'd8, S_HALT = 4'd9
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

  state_e     state_q, state_d;
  logic       in_t;
  logic [2:0] t_idx;
  logic [2:0] last_step;

  // State register; reset drops every strobe immediately, aborting any RAM write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign in_t    = ~state_q[3];
  assign t_idx   = state_q[2:0];
  assign t_state = in_t ? t_idx : 3'd0;
  assign halt    = (state_q == S_HALT);

  // Final step of the current instruction (opcode is stable from T2 onward).
  always_comb begin
    last_step = 3'(T_STEPS - 1);
`ifdef CTRL_EARLY_END_EN
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
`endif
  end

  // Next-state: step forward while enabled, wrap after the last step, HLT parks in S_HALT.
  always_comb begin
    state_d = state_q;
    if (run_en) begin
      case (state_q)
        S_RST:  state_d = S_T0;
        S_HALT: state_d = S_HALT;
        default: begin
          if (state_q == S_T2 && opcode == OP_HLT) state_d = S_HALT;
          else if (t_idx >= last_step)             state_d = S_T0;
          else                                     state_d = state_e'({1'b0, t_idx + 3'd1});
        end
      endcase
    end
  end

  // Strobe decode; everything low unless running in a T-state that uses it.
  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; mar_in = 1'b0;
    ram_in = 1'b0; ram_out = 1'b0; ir_in = 1'b0; ir_out = 1'b0;
    a_in = 1'b0; a_out = 1'b0; b_in = 1'b0; alu_out = 1'b0;
    alu_sub = 1'b0; flags_in = 1'b0; out_in = 1'b0;
    if (run_en) begin
      case (state_q)
        S_T0: begin pc_out = 1'b1; mar_in = 1'b1; end
        S_T1: begin ram_out = 1'b1; ir_in = 1'b1; pc_inc = 1'b1; end
        S_T2: begin
          case (opcode)
            OP_NOP: ;
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out = 1'b1; mar_in = 1'b1; end
            OP_LDI: begin ir_out = 1'b1; a_in = 1'b1; end
            OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; end
            OP_JC:  begin ir_out = flag_c; pc_load = flag_c; end
            OP_JZ:  begin ir_out = flag_z; pc_load = flag_z; end
            OP_OUT: begin a_out = 1'b1; out_in = 1'b1; end
            default: ;
          endcase
        end
        S_T3: begin
          case (opcode)
            OP_LDA:         begin ram_out = 1'b1; a_in = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out = 1'b1; b_in = 1'b1; end
            OP_STA:         begin a_out = 1'b1; ram_in = 1'b1; end
            default: ;
          endcase
        end
        S_T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: directed cycles push expected strobes, a negedge monitor compares.
// Expectations are hand-written per cycle for the default T_STEPS=5 build.
// Padding cycles after the last strobe step are skipped when CTRL_EARLY_END_EN is defined.
module tb_cpu_ctrl_seq;

  logic clk, rst_n, run_en, flag_c, flag_z;
  logic [3:0] opcode;
  logic pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
  logic [2:0] t_state;

  cpu_ctrl_seq #(.OP_W(4), .T_STEPS(5)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in),
    .halt(halt), .t_state(t_state)
  );

`ifdef CTRL_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] PO = 15'h0001, PI = 15'h0002, PL = 15'h0004, MI = 15'h0008;
  localparam logic [14:0] RI = 15'h0010, RO = 15'h0020, II = 15'h0040, IO = 15'h0080;
  localparam logic [14:0] AI = 15'h0100, AO = 15'h0200, BI = 15'h0400, EO = 15'h0800;
  localparam logic [14:0] SU = 15'h1000, FI = 15'h2000, OI = 15'h4000;

  typedef struct {
    int         idx;
    logic [14:0] stb;
    logic        hlt;
    logic [2:0]  t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;
  logic [14:0] act;

  assign act = {out_in, flags_in, alu_sub, alu_out, b_in, a_out, a_in, ir_out,
                ir_in, ram_out, ram_in, mar_in, pc_load, pc_inc, pc_out};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations left", sb.size());
    $fatal(1, "watchdog expired");
  end

  // Monitor: every cycle compare the oldest expectation and check the bus has at most one driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
        errors++;
        $display("FAIL bus_onehot: drivers pc/ram/ir/a/alu = %b, required at most one high",
                 {pc_out, ram_out, ir_out, a_out, alu_out});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({act, halt, t_state} !== {e.stb, e.hlt, e.t}) begin
          errors++;
          $display("FAIL step%0d: got stb=%h halt=%b t=%0d, required stb=%h halt=%b t=%0d",
                   e.idx, act, halt, t_state, e.stb, e.hlt, e.t);
        end
      end
    end
  end

  task automatic cyc(input logic run, input logic [3:0] op, input logic fc, input logic fz,
                     input logic [14:0] stb, input logic hlt, input logic [2:0] t);
    exp_t e;
    run_en = run; opcode = op; flag_c = fc; flag_z = fz;
    e.idx = n_step; e.stb = stb; e.hlt = hlt; e.t = t;
    sb.push_back(e);
    n_step++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op);
    cyc(1'b1, op, 1'b0, 1'b0, PO | MI, 1'b0, 3'd0);
    cyc(1'b1, op, 1'b0, 1'b0, RO | II | PI, 1'b0, 3'd1);
  endtask

  // Strobe-free step that only exists when instructions run the full T_STEPS.
  task automatic tail(input logic [3:0] op, input logic [2:0] t);
    if (!EARLY) cyc(1'b1, op, 1'b0, 1'b0, NONE, 1'b0, t);
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    // Held in reset, then the first released cycle is still S_RST.
    cyc(1'b1, 4'h1, 1'b0, 1'b0, NONE, 1'b0, 3'd0);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, NONE, 1'b0, 3'd0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h1, 1'b0, 1'b0, NONE, 1'b0, 3'd0);

    // Program LDA, ADD, JMP.
    fetch(4'h1);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, IO | MI, 1'b0, 3'd2);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, RO | AI, 1'b0, 3'd3);
    tail(4'h1, 3'd4);
    fetch(4'h2);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, IO | MI, 1'b0, 3'd2);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, RO | BI, 1'b0, 3'd3);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, EO | AI | FI, 1'b0, 3'd4);
    fetch(4'h6);
    cyc(1'b1, 4'h6, 1'b0, 1'b0, IO | PL, 1'b0, 3'd2);
    tail(4'h6, 3'd3);
    tail(4'h6, 3'd4);

    // SUB selects subtract only in T4.
    fetch(4'h3);
    cyc(1'b1, 4'h3, 1'b0, 1'b0, IO | MI, 1'b0, 3'd2);
    cyc(1'b1, 4'h3, 1'b0, 1'b0, RO | BI, 1'b0, 3'd3);
    cyc(1'b1, 4'h3, 1'b0, 1'b0, EO | AI | FI | SU, 1'b0, 3'd4);

    // JC not taken, then taken; JZ taken with carry clear.
    fetch(4'h7);
    cyc(1'b1, 4'h7, 1'b0, 1'b1, NONE, 1'b0, 3'd2);
    tail(4'h7, 3'd3);
    tail(4'h7, 3'd4);
    fetch(4'h7);
    cyc(1'b1, 4'h7, 1'b1, 1'b0, IO | PL, 1'b0, 3'd2);
    tail(4'h7, 3'd3);
    tail(4'h7, 3'd4);
    fetch(4'h8);
    cyc(1'b1, 4'h8, 1'b0, 1'b1, IO | PL, 1'b0, 3'd2);
    tail(4'h8, 3'd3);
    tail(4'h8, 3'd4);

    // LDI, OUT, NOP and an unlisted opcode.
    fetch(4'h5);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, IO | AI, 1'b0, 3'd2);
    tail(4'h5, 3'd3);
    tail(4'h5, 3'd4);
    fetch(4'hE);
    cyc(1'b1, 4'hE, 1'b0, 1'b0, AO | OI, 1'b0, 3'd2);
    tail(4'hE, 3'd3);
    tail(4'hE, 3'd4);
    fetch(4'h0);
    cyc(1'b1, 4'h0, 1'b1, 1'b1, NONE, 1'b0, 3'd2);
    tail(4'h0, 3'd3);
    tail(4'h0, 3'd4);
    fetch(4'hA);
    cyc(1'b1, 4'hA, 1'b1, 1'b1, NONE, 1'b0, 3'd2);
    tail(4'hA, 3'd3);
    tail(4'hA, 3'd4);

    // STA frozen for three cycles in T3, then the write happens exactly once.
    fetch(4'h4);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, IO | MI, 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h4, 1'b0, 1'b0, NONE, 1'b0, 3'd3);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, AO | RI, 1'b0, 3'd3);
    tail(4'h4, 3'd4);

    // Reset in the middle of a STA write drops the write at once.
    fetch(4'h4);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, IO | MI, 1'b0, 3'd2);
    rst_n = 1'b0;
    cyc(1'b1, 4'h4, 1'b0, 1'b0, NONE, 1'b0, 3'd0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h4, 1'b0, 1'b0, NONE, 1'b0, 3'd0);

    // HLT: halted with no strobes until a reset pulse.
    fetch(4'hF);
    cyc(1'b1, 4'hF, 1'b0, 1'b0, NONE, 1'b0, 3'd2);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'hF, 1'b1, 1'b1, NONE, 1'b1, 3'd0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0, NONE, 1'b1, 3'd0);
    rst_n = 1'b0;
    cyc(1'b1, 4'h2, 1'b0, 1'b0, NONE, 1'b0, 3'd0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h2, 1'b0, 1'b0, NONE, 1'b0, 3'd0);
    fetch(4'h1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
